tile_inj_arb: RTL and testbench
===============================

# tile_inj_arb

Packet-atomic injection arbiter that shares the single local input port of the tile NoC router among `NREQ` local AXI-stream requesters (core, memory manager, dispatcher, message-queue engine). It picks a requester by quota-limited round-robin, locks the grant until that packet's `TLAST` beat is accepted, and passes beats through unmodified. The block sits between the tile's local agents and the router's `stream_in_local_in_*` port.

## Interface

Parameters:

- `NREQ`, 4: number of requesters, 2..8.
- `BW`, 32: data width in bits.
- `BWB`, `BW/8`: keep width.
- `QUOTA`, 2: maximum consecutive packets one requester may send while others wait, ≥1.
- `WDOG_CYCLES`, 256: mid-packet starvation limit in cycles. Used only with `TILE_INJ_ARB_WDOG_EN`.

Ports:

- `clk_line`, in, 1: single clock. All logic is on the rising edge.
- `clk_line_rst_high`, in, 1: reset, synchronous and active-high.
- `req_TVALID`, in, NREQ: requester valid; bit i is requester i.
- `req_TDATA`, in, NREQ*BW: requester data; slice i is `[(i+1)*BW-1 : i*BW]`.
- `req_TKEEP`, in, NREQ*BWB: requester keep.
- `req_TLAST`, in, NREQ: requester last beat.
- `req_TREADY`, out, NREQ: ready back to each requester.
- `noc_TVALID`, out, 1: valid to the router local input.
- `noc_TDATA`, out, BW: data to the router.
- `noc_TKEEP`, out, BWB: keep to the router.
- `noc_TLAST`, out, 1: last to the router.
- `noc_TREADY`, in, 1: ready from the router.
- `grant_id`, out, clog2(NREQ): currently or last selected requester.
- `busy`, out, 1: high while a packet is locked.
- `wdog_clr`, in, 1: clears `wdog_err` and unmasks requesters.
- `wdog_err`, out, NREQ: sticky per-requester starvation flag.

## Operation

States:

- **IDLE**
  - All `req_TREADY` are 0 and `noc_TVALID` is 0.
  - If any unmasked `req_TVALID` is high, select a requester:
    - Pick `sel` again if `served_cnt < QUOTA` and `req_TVALID[sel]` is high.
    - Otherwise pick the first valid, unmasked requester scanning from `sel+1` with modulo-NREQ wrap.
  - On a new pick, set `served_cnt=1`; on a repeat pick, increment `served_cnt`.
  - Register `sel` and go to LOCK.
- **LOCK**
  - Combinational pass-through:
    - `noc_T{VALID,DATA,KEEP,LAST}` come from slice `sel`.
    - `req_TREADY[sel] = noc_TREADY`; all other `req_TREADY` are 0.
  - When a beat with `TLAST` is accepted (`noc_TVALID & noc_TREADY & noc_TLAST`), go to IDLE.

Rules:

- Packets are never interleaved. Only requester `sel` can complete a handshake in LOCK.
- In IDLE, `noc_TDATA`, `noc_TKEEP` and `noc_TLAST` are driven to 0.
- `busy` is 1 exactly in LOCK.
- `grant_id` equals `sel`.
- Masked requesters (watchdog) have `req_TREADY=0` and are skipped by the scan.
- `wdog_clr` and a watchdog fire in the same cycle: the fire wins for that requester.
- A reset mid-packet abandons the packet. The requester must restart it; the bench drives no partial-packet recovery.

Reset values:

- `sel = NREQ-1`, so the first scan starts at requester 0.
- `served_cnt = 0`.
- State is IDLE.
- All outputs are 0, and `grant_id = NREQ-1`.

## Timing

- Data path latency is 0 cycles (combinational mux). `req_TREADY` depends combinationally on `noc_TREADY`.
- There is one bubble cycle (IDLE) after every packet, including a repeat grant to the same requester.
- A single-beat packet occupies 2 cycles minimum: 1 IDLE plus 1 LOCK.
- Back-pressure (`noc_TREADY=0`) holds LOCK indefinitely. It is not a fault.
- The grant decision is made at the IDLE clock edge using that cycle's `req_TVALID`. A requester that deasserts `TVALID` after being selected is not a protocol violation.

## Configuration

Macro: `TILE_INJ_ARB_WDOG_EN`.

Defined:

- A counter of width clog2(WDOG_CYCLES+1) increments in each LOCK cycle where `req_TVALID[sel]=0`.
- The counter clears on every accepted beat and on entry to LOCK.
- When it reaches `WDOG_CYCLES`:
  - Set `wdog_err[sel]` and `mask[sel]`.
  - Force `served_cnt = QUOTA`.
  - Go to IDLE next cycle. No `TLAST` is injected.
- A masked requester stays excluded until `wdog_clr` is asserted.

Undefined:

- No counter and no mask.
- `wdog_err` is tied to 0 and `wdog_clr` is ignored.
- A stalled requester holds the lock forever.

## Test plan

- **Reset:** assert `clk_line_rst_high` 2 cycles with all `req_TVALID=1` → during reset all `req_TREADY=0`, `noc_TVALID=0`, `busy=0`, `grant_id=3`; first grant after reset is requester 0.
- **Fairness:** all 4 requesters continuously offer 3-beat packets, `QUOTA=2`, `noc_TREADY=1` → grant order 0,0,1,1,2,2,3,3,0; each packet takes 4 cycles; beats of different requesters are never interleaved.
- **Back-pressure:** requester 2 sends 4 beats `0xA0`..`0xA3` while `noc_TREADY` toggles 1,0,1,0… → output shows `0xA0`..`0xA3` in order with `TKEEP` unchanged; requester 1 valid throughout receives no `TREADY` until requester 2's `TLAST` is accepted.
- **Quota and wrap:** only requester 3 valid, 5 single-beat packets → all 5 go to requester 3, `grant_id` stays 3; then requester 0 becomes valid → its packet is served when requester 3's current quota expires, after the wrap 3→0.
- **Watchdog (with `TILE_INJ_ARB_WDOG_EN`, `WDOG_CYCLES=16`):** requester 1 sends 1 beat without `TLAST`, then drops `TVALID` → after 16 stall cycles `wdog_err=4'b0010`, `busy=0`, requester 0 is granted next; requester 1 is ignored until a `wdog_clr` pulse.
- **Watchdog off (macro undefined):** same stimulus → `busy` stays 1 for 1000 cycles and `wdog_err=0`.

Source files
------------

// File: rtl/tile_inj_arb.sv
// Packet-atomic, quota-limited round-robin arbiter feeding the tile router local input port.
// Optional mid-packet starvation watchdog is enabled by defining TILE_INJ_ARB_WDOG_EN.
module tile_inj_arb #(
    parameter int NREQ        = 4,
    parameter int BW          = 32,
    parameter int BWB         = BW / 8,
    parameter int QUOTA       = 2,
    parameter int WDOG_CYCLES = 256
) (
    input  logic                    clk_line,
    input  logic                    clk_line_rst_high,
    input  logic [NREQ-1:0]         req_TVALID,
    input  logic [NREQ*BW-1:0]      req_TDATA,
    input  logic [NREQ*BWB-1:0]     req_TKEEP,
    input  logic [NREQ-1:0]         req_TLAST,
    output logic [NREQ-1:0]         req_TREADY,
    output logic                    noc_TVALID,
    output logic [BW-1:0]           noc_TDATA,
    output logic [BWB-1:0]          noc_TKEEP,
    output logic                    noc_TLAST,
    input  logic                    noc_TREADY,
    output logic [$clog2(NREQ)-1:0] grant_id,
    output logic                    busy,
    input  logic                    wdog_clr,
    output logic [NREQ-1:0]         wdog_err
);

    localparam int GW = $clog2(NREQ);
    localparam int CW = $clog2(QUOTA + 1);
    localparam logic [GW-1:0] LAST_ID = GW'(NREQ - 1);
    localparam logic [CW-1:0] QUOTA_C = CW'(QUOTA);

    typedef enum logic {IDLE = 1'b0, LOCK = 1'b1} state_t;

    state_t          state;
    logic [GW-1:0]   sel;
    logic [CW-1:0]   served_cnt;
    logic [NREQ-1:0] mask;
    logic [NREQ-1:0] avail;
    logic [GW-1:0]   next_sel;
    logic [GW-1:0]   cand;
    logic            repeat_pick;
    logic            beat_acc;
    logic            accept_last;
    logic            wdog_fire;

    assign avail       = req_TVALID & ~mask;
    // served_cnt of zero means nobody has been served since reset, so it is never a repeat
    assign repeat_pick = (served_cnt != '0) && (served_cnt < QUOTA_C) && avail[sel];
    assign beat_acc    = noc_TVALID & noc_TREADY;
    assign accept_last = beat_acc & noc_TLAST;
    assign busy        = (state == LOCK);
    assign grant_id    = sel;

    // Descending loop so the closest requester after sel is the last (winning) assignment
    always_comb begin
        next_sel = sel;
        cand     = sel;
        for (int k = NREQ; k >= 1; k--) begin
            cand = GW'((int'(sel) + k) % NREQ);
            if (avail[cand]) next_sel = cand;
        end
    end

    always_comb begin
        noc_TVALID = 1'b0;
        noc_TDATA  = '0;
        noc_TKEEP  = '0;
        noc_TLAST  = 1'b0;
        req_TREADY = '0;
        if (state == LOCK) begin
            noc_TVALID      = req_TVALID[sel];
            noc_TDATA       = req_TDATA[int'(sel)*BW +: BW];
            noc_TKEEP       = req_TKEEP[int'(sel)*BWB +: BWB];
            noc_TLAST       = req_TLAST[sel];
            req_TREADY[sel] = noc_TREADY;
        end
    end

    always_ff @(posedge clk_line) begin
        if (clk_line_rst_high) begin
            state      <= IDLE;
            sel        <= LAST_ID;
            served_cnt <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (|avail) begin
                        state <= LOCK;
                        if (repeat_pick) begin
                            served_cnt <= served_cnt + CW'(1);
                        end else begin
                            sel        <= next_sel;
                            served_cnt <= CW'(1);
                        end
                    end
                end
                LOCK: begin
                    if (accept_last) begin
                        state <= IDLE;
                    end else if (wdog_fire) begin
                        state      <= IDLE;
                        served_cnt <= QUOTA_C;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

`ifdef TILE_INJ_ARB_WDOG_EN
    localparam int WW = $clog2(WDOG_CYCLES + 1);
    localparam logic [WW-1:0] WDOG_LAST = WW'(WDOG_CYCLES - 1);

    logic [WW-1:0]   wdog_cnt;
    logic [NREQ-1:0] sel_onehot;

    assign sel_onehot = NREQ'(1) << sel;
    // Fires on the stall cycle that would bring the count to WDOG_CYCLES
    assign wdog_fire  = (state == LOCK) && !req_TVALID[sel] && (wdog_cnt == WDOG_LAST);
    assign wdog_err   = mask;

    always_ff @(posedge clk_line) begin
        if (clk_line_rst_high) begin
            wdog_cnt <= '0;
            mask     <= '0;
        end else begin
            if ((state != LOCK) || beat_acc || wdog_fire) begin
                wdog_cnt <= '0;
            end else if (!req_TVALID[sel]) begin
                wdog_cnt <= wdog_cnt + WW'(1);
            end
            mask <= (wdog_clr ? '0 : mask) | (wdog_fire ? sel_onehot : '0);
        end
    end
`else
    logic unused_wdog;

    assign unused_wdog = wdog_clr ^ WDOG_CYCLES[0];
    assign wdog_fire   = 1'b0;
    assign mask        = '0;
    assign wdog_err    = '0;
`endif

endmodule

// File: tb/tb_tile_inj_arb.sv
// Scoreboard bench for tile_inj_arb: directed reset, quota/wrap, back-pressure, fairness and watchdog steps.
// Watchdog expectations follow TILE_INJ_ARB_WDOG_EN.
module tb_tile_inj_arb;

    localparam int NREQ  = 4;
    localparam int BW    = 32;
    localparam int BWB   = 4;
    localparam int QUOTA = 2;
    localparam int WDOG  = 16;

    typedef struct packed {
        logic [1:0]     id;
        logic [BW-1:0]  data;
        logic [BWB-1:0] keep;
        logic           last;
    } beat_t;

    logic                clk_line = 1'b0;
    logic                clk_line_rst_high;
    logic [NREQ-1:0]     req_TVALID;
    logic [NREQ*BW-1:0]  req_TDATA;
    logic [NREQ*BWB-1:0] req_TKEEP;
    logic [NREQ-1:0]     req_TLAST;
    logic [NREQ-1:0]     req_TREADY;
    logic                noc_TVALID;
    logic [BW-1:0]       noc_TDATA;
    logic [BWB-1:0]      noc_TKEEP;
    logic                noc_TLAST;
    logic                noc_TREADY;
    logic [1:0]          grant_id;
    logic                busy;
    logic                wdog_clr;
    logic [NREQ-1:0]     wdog_err;

    beat_t           srcq[NREQ][$];
    beat_t           expq[$];
    int              lastq[$];
    logic [NREQ-1:0] en;
    beat_t           tmp;
    int              total  = 0;
    int              bad    = 0;
    int              cycle  = 0;
    int              n_last = 0;

    tile_inj_arb #(
        .NREQ(NREQ), .BW(BW), .BWB(BWB), .QUOTA(QUOTA), .WDOG_CYCLES(WDOG)
    ) dut (
        .clk_line(clk_line),
        .clk_line_rst_high(clk_line_rst_high),
        .req_TVALID(req_TVALID),
        .req_TDATA(req_TDATA),
        .req_TKEEP(req_TKEEP),
        .req_TLAST(req_TLAST),
        .req_TREADY(req_TREADY),
        .noc_TVALID(noc_TVALID),
        .noc_TDATA(noc_TDATA),
        .noc_TKEEP(noc_TKEEP),
        .noc_TLAST(noc_TLAST),
        .noc_TREADY(noc_TREADY),
        .grant_id(grant_id),
        .busy(busy),
        .wdog_clr(wdog_clr),
        .wdog_err(wdog_err)
    );

    always #5 clk_line = ~clk_line;

    task automatic checkOutput(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("[TB] FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    function automatic beat_t makeBeat(input int id, input int pkt, input int b, input int n);
        beat_t t;
        t.id   = 2'(id);
        t.data = {8'(id), 8'(pkt), 8'(b), 8'h5A};
        t.keep = (b == n - 1) ? 4'b0111 : 4'b1111;
        t.last = (b == n - 1);
        return t;
    endfunction

    task automatic addPacket(input int id, input int pkt, input int n);
        for (int b = 0; b < n; b++) srcq[id].push_back(makeBeat(id, pkt, b, n));
    endtask

    task automatic expectPacket(input int id, input int pkt, input int n);
        for (int b = 0; b < n; b++) expq.push_back(makeBeat(id, pkt, b, n));
    endtask

    // Present the head beat of every enabled requester queue
    task automatic applyStimulus();
        for (int i = 0; i < NREQ; i++) begin
            if (en[i] && srcq[i].size() > 0) begin
                req_TVALID[i]           = 1'b1;
                req_TDATA[i*BW +: BW]   = srcq[i][0].data;
                req_TKEEP[i*BWB +: BWB] = srcq[i][0].keep;
                req_TLAST[i]            = srcq[i][0].last;
            end else begin
                req_TVALID[i]           = 1'b0;
                req_TDATA[i*BW +: BW]   = '0;
                req_TKEEP[i*BWB +: BWB] = '0;
                req_TLAST[i]            = 1'b0;
            end
        end
    endtask

    // Sample on the falling edge, then advance past the rising edge and retire accepted beats
    task automatic tick();
        logic [NREQ-1:0] pops;
        logic [NREQ-1:0] oh;
        beat_t           e;
        @(negedge clk_line);
        cycle++;
        pops = req_TVALID & req_TREADY;
        if (!busy) begin
            checkOutput("idle_quiet", 64'({req_TREADY, noc_TVALID, noc_TDATA, noc_TKEEP, noc_TLAST}), 64'd0);
        end else if (expq.size() > 0) begin
            oh = 4'b0001 << expq[0].id;
            checkOutput("lock_route", 64'({grant_id, req_TREADY}),
                        64'({expq[0].id, (noc_TREADY ? oh : 4'b0000)}));
        end
        if (noc_TVALID && noc_TREADY) begin
            checkOutput("beat_pending", 64'(expq.size() > 0), 64'd1);
            if (expq.size() > 0) begin
                e = expq.pop_front();
                checkOutput("beat", 64'({grant_id, noc_TDATA, noc_TKEEP, noc_TLAST}),
                            64'({e.id, e.data, e.keep, e.last}));
            end
            if (noc_TLAST) begin
                lastq.push_back(cycle);
                n_last++;
            end
        end
        @(posedge clk_line);
        #1;
        for (int i = 0; i < NREQ; i++) if (pops[i]) srcq[i].delete(0);
        applyStimulus();
    endtask

    task automatic runUntilDrained(input string tag, input int max_cycles);
        for (int k = 0; k < max_cycles && expq.size() > 0; k++) tick();
        checkOutput({tag, "_drained"}, 64'(expq.size()), 64'd0);
    endtask

    task automatic runUntilLasts(input string tag, input int target, input int max_cycles);
        for (int k = 0; k < max_cycles && n_last < target; k++) tick();
        checkOutput({tag, "_lasts"}, 64'(n_last), 64'(target));
    endtask

    initial begin
        clk_line_rst_high = 1'b1;
        noc_TREADY        = 1'b1;
        wdog_clr          = 1'b0;
        en                = '1;
        req_TVALID        = '0;
        req_TDATA         = '0;
        req_TKEEP         = '0;
        req_TLAST         = '0;

        $display("[TB] reset with all requesters valid");
        for (int i = 0; i < NREQ; i++) addPacket(i, 0, 1);
        applyStimulus();
        @(posedge clk_line); #1;
        @(negedge clk_line);
        checkOutput("rst_tready", 64'(req_TREADY), 64'd0);
        checkOutput("rst_noc_valid", 64'(noc_TVALID), 64'd0);
        checkOutput("rst_busy", 64'(busy), 64'd0);
        checkOutput("rst_grant_id", 64'(grant_id), 64'd3);
        checkOutput("rst_wdog_err", 64'(wdog_err), 64'd0);
        @(posedge clk_line); #1;
        clk_line_rst_high = 1'b0;
        for (int i = 0; i < NREQ; i++) expectPacket(i, 0, 1);
        runUntilDrained("reset_order", 40);

        $display("[TB] quota and wrap on requester 3");
        en = 4'b1000;
        for (int p = 1; p <= 7; p++) addPacket(3, p, 1);
        addPacket(0, 1, 1);
        for (int p = 1; p <= 5; p++) expectPacket(3, p, 1);
        expectPacket(0, 1, 1);
        expectPacket(3, 6, 1);
        expectPacket(3, 7, 1);
        applyStimulus();
        runUntilLasts("quota_first4", n_last + 4, 30);
        en = 4'b1001;
        applyStimulus();
        runUntilDrained("quota_wrap", 30);

        $display("[TB] back-pressure on requester 2");
        en = 4'b0100;
        for (int b = 0; b < 4; b++) begin
            tmp.id   = 2'd2;
            tmp.data = 32'hA0 + 32'(b);
            tmp.keep = 4'b1111 << b;
            tmp.last = (b == 3);
            srcq[2].push_back(tmp);
            expq.push_back(tmp);
        end
        addPacket(1, 2, 1);
        expectPacket(1, 2, 1);
        applyStimulus();
        tick();
        en = 4'b0110;
        applyStimulus();
        for (int k = 0; k < 40 && expq.size() > 1; k++) begin
            noc_TREADY = (k % 2 == 0);
            tick();
        end
        noc_TREADY = 1'b1;
        runUntilDrained("backpressure", 20);

        $display("[TB] fairness after a fresh reset");
        clk_line_rst_high = 1'b1;
        tick();
        tick();
        clk_line_rst_high = 1'b0;
        en = '1;
        lastq.delete();
        addPacket(0, 10, 3); addPacket(0, 11, 3); addPacket(0, 12, 3);
        addPacket(1, 10, 3); addPacket(1, 11, 3);
        addPacket(2, 10, 3); addPacket(2, 11, 3);
        addPacket(3, 10, 3); addPacket(3, 11, 3);
        expectPacket(0, 10, 3); expectPacket(0, 11, 3);
        expectPacket(1, 10, 3); expectPacket(1, 11, 3);
        expectPacket(2, 10, 3); expectPacket(2, 11, 3);
        expectPacket(3, 10, 3); expectPacket(3, 11, 3);
        expectPacket(0, 12, 3);
        applyStimulus();
        runUntilDrained("fairness", 100);
        checkOutput("fair_packets", 64'(lastq.size()), 64'd9);
        for (int k = 1; k < lastq.size(); k++)
            checkOutput("fair_spacing", 64'(lastq[k] - lastq[k-1]), 64'd4);

        $display("[TB] stalled mid-packet requester 1");
        tmp = makeBeat(1, 9, 0, 3);
        srcq[1].push_back(tmp);
        expq.push_back(tmp);
        applyStimulus();
        runUntilDrained("stall_beat", 10);
`ifdef TILE_INJ_ARB_WDOG_EN
        for (int k = 0; k < WDOG - 1; k++) tick();
        @(negedge clk_line);
        checkOutput("wd_busy_before_fire", 64'(busy), 64'd1);
        @(posedge clk_line); #1;
        @(negedge clk_line);
        checkOutput("wd_busy_after_fire", 64'(busy), 64'd0);
        checkOutput("wd_err_set", 64'(wdog_err), 64'h2);
        @(posedge clk_line); #1;
        addPacket(0, 5, 1);
        addPacket(1, 5, 1);
        expectPacket(0, 5, 1);
        applyStimulus();
        for (int k = 0; k < 20; k++) tick();
        checkOutput("wd_masked_pending", 64'(srcq[1].size()), 64'd1);
        checkOutput("wd_err_sticky", 64'(wdog_err), 64'h2);
        expectPacket(1, 5, 1);
        wdog_clr = 1'b1;
        tick();
        wdog_clr = 1'b0;
        runUntilDrained("wd_after_clr", 20);
        @(negedge clk_line);
        checkOutput("wd_err_cleared", 64'(wdog_err), 64'd0);
        @(posedge clk_line); #1;
`else
        for (int k = 0; k < 1000; k++) begin
            tick();
            if (k % 100 == 99) begin
                checkOutput("wdoff_busy", 64'(busy), 64'd1);
                checkOutput("wdoff_err", 64'(wdog_err), 64'd0);
            end
        end
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
